// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer: widths and state codes.
// Code 2'd3 is not a legal state; the controller steers it back to StIdle.
package shift_add_mult_ctrl_pkg;

  localparam int unsigned OpW  = 10;
  localparam int unsigned AccW = 20;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// Shared ripple-carry adder: sum/cout = a + b + cin, carry rippling from bit 0 upward.
module shift_add_mult_ctrl_adder #(
  parameter int unsigned W = 20
) (
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for a 10x10 unsigned shift-and-add multiply: one adder pass per cycle,
// fixed 10-step run, valid/ready handshakes on both operand and result sides.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int unsigned OP_W  = OpW,
  parameter int unsigned ACC_W = AccW,
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] product,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]    mplr_q, mplr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   product_q, product_d;

  logic [ACC_W-1:0]   add_b;
  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;

  assign add_b = mplr_q[0] ? mcand_q : '0;

  shift_add_mult_ctrl_adder #(
    .W (ACC_W)
  ) u_add (
    .cin  (1'b0),
    .a    (acc_q),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = ACC_W'(a);
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = add_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OP_W - 1)) begin
          // Result register holds until the next run completes, not just until hand-off.
          product_d = add_sum;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign product   = product_q;

  // A 10x10 product always fits in 20 bits, so the adder can never carry out.
  cout_never_set : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StRun) |-> !add_cout);

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: directed corner cases plus 200 random back-to-back
// multiplies, expected products from plain a*b, checked by a negedge monitor.
module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  a;
  logic [9:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] product;
  logic        busy;

  shift_add_mult_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned prod;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   b2b      = 1'b0;
  int   last_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: samples on the falling edge, between the DUT's active edges.
  bit          prev_ov   = 1'b0;
  bit          prev_hand = 1'b0;
  logic [19:0] held      = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      prev_hand = 1'b0;
    end else begin
      if (busy) begin
        chk("run_in_ready_low", in_ready, 0);
        chk("run_cout_zero", dut.add_cout, 0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{prod: int'(a) * int'(b), acc_cyc: cyc});
        if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 12);
        last_acc = cyc;
      end
      if (prev_ov && !prev_hand) begin
        chk("out_valid_held", out_valid, 1);
        if (out_valid) chk("product_held", product, held);
      end
      if (out_valid && !(prev_ov && !prev_hand)) begin
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("latency", cyc - exp_q[0].acc_cyc, 11);
        held = product;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("product", product, exp_q[0].prod);
        void'(exp_q.pop_front());
      end
      prev_ov   = out_valid;
      prev_hand = out_valid && out_ready;
    end
  end

  task automatic send(input logic [9:0] va, input logic [9:0] vb);
    bit seen;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      #1;
      done = seen;
    end
    if (!done) chk("send_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_product"}, product, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Widest operands, then zeros and ones.
    out_ready = 1'b1;
    send(10'd1023, 10'd1023);
    drain();
    chk("max_product_retained", product, 20'hFF801);
    send(10'd0, 10'd777);
    drain();
    send(10'd777, 10'd0);
    drain();
    send(10'd1, 10'd1);
    drain();
    chk("one_product_retained", product, 1);

    // Back-pressure in DONE for five cycles.
    out_ready = 1'b0;
    send(10'd37, 10'd25);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 925);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_in_ready", in_ready, 1);
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_product_kept", product, 925);

    // Request during RUN must be ignored.
    send(10'd3, 10'd4);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = 10'd5;
    b        = 10'd5;
    chk("run_req_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("ignored_req_product", product, 12);

    // Asynchronous reset partway through a run.
    send(10'd100, 10'd100);
    repeat (4) @(posedge clk);
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(10'd2, 10'd3);
    drain();
    chk("post_reset_product", product, 6);

    // Random back-to-back stream with the consumer always ready.
    b2b      = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 200; i++) begin
      send(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    end
    drain();
    b2b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
